// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory controller.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_e;

  // Read-modify-write payload held between the read and write phases
  typedef struct packed {
    logic [ADDR_W-3:0] waddr;
    logic [DATA_W-1:0] word;
  } rmw_t;

  // Reserved size 2'b11 behaves as a word access
  function automatic logic is_misaligned(input logic [SIZE_W-1:0] size,
                                         input logic [1:0]        lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [SIZE_W-1:0] i_size,
  input  logic              i_unsigned,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_size)
      SZ_BYTE: o_load_data = i_unsigned ? {{(DATA_W-8){1'b0}}, w_byte}
                                        : {{(DATA_W-8){w_byte[7]}}, w_byte};
      SZ_HALF: o_load_data = i_unsigned ? {{(DATA_W-16){1'b0}}, w_half}
                                        : {{(DATA_W-16){w_half[15]}}, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

  // Old word with the addressed lane(s) replaced; a word store replaces everything
  always_comb begin
    o_merged = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        case (i_addr_lo)
          2'b01:   o_merged[15:8]  = i_wdata[7:0];
          2'b10:   o_merged[23:16] = i_wdata[7:0];
          2'b11:   o_merged[31:24] = i_wdata[7:0];
          default: o_merged[7:0]   = i_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
        else              o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller with read-modify-write for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_mem_ctrl
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [SIZE_W-1:0] req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            r_state;
  state_e            w_state_nxt;
  rmw_t              r_rmw;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_misalign;

  logic              w_mis;
  logic              w_subword;
  logic              w_load_fire;
  logic              w_rmw_fire;
  logic              w_mis_fire;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = is_misaligned(req_size, req_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  assign w_subword = (req_size == SZ_BYTE) || (req_size == SZ_HALF);

  lsu_align u_align (
    .i_size      (req_size),
    .i_unsigned  (req_unsigned),
    .i_addr_lo   (req_addr[1:0]),
    .i_rdata     (mem_rdata),
    .i_wdata     (req_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // Next state and memory-side strobes; everything is suppressed while in reset
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = {req_addr[ADDR_W-1:2], 2'b00};
    mem_wdata   = req_wdata;
    w_load_fire = 1'b0;
    w_rmw_fire  = 1'b0;
    w_mis_fire  = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (w_mis) begin
              w_mis_fire = 1'b1;
            end else if (!req_we) begin
              mem_re      = 1'b1;
              w_load_fire = 1'b1;
            end else if (w_subword) begin
              mem_re      = 1'b1;
              stall       = 1'b1;
              w_rmw_fire  = 1'b1;
              w_state_nxt = ST_MERGE;
            end else begin
              mem_we = 1'b1;
            end
          end
        end
        ST_MERGE: begin
          mem_we      = 1'b1;
          mem_addr    = {r_rmw.waddr, 2'b00};
          mem_wdata   = r_rmw.word;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rmw       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_load_fire;
      r_misalign  <= w_mis_fire;
      if (w_load_fire) r_rsp_rdata <= w_load_data;
      if (w_rmw_fire) begin
        r_rmw.waddr <= req_addr[ADDR_W-1:2];
        r_rmw.word  <= w_merged;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign misalign  = r_misalign;

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 The block SHALL provide the following ports, clock and reset first; reset is synchronous and active-high, and all state changes occur on the rising edge of `clk`.
- `clk`  in  1  single system clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  EX/MEM stage memory operation present
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  access size: 00 byte, 01 half, 10 word; 11 reserved, treated as word
- `req_unsigned`  in  1  zero-extend loads
- `req_addr`  in  32  byte address (ALU result)
- `req_wdata`  in  32  store data, right-aligned
- `stall`  out  1  hold the EX/MEM register this cycle
- `rsp_valid`  out  1  load data valid, registered
- `rsp_rdata`  out  32  extended load data
- `misalign`  out  1  misaligned-access pulse, registered
- `mem_addr`  out  32  word-aligned byte address: {req_addr[31:2], 2'b00}
- `mem_wdata`  out  32  full word to write
- `mem_we`  out  1  memory write strobe, word granular
- `mem_re`  out  1  memory read enable
- `mem_rdata`  in  32  combinational read data from the memory

Function
REQ-002 FSM states SHALL be IDLE and MERGE; reset state is IDLE.
REQ-003 In IDLE, a word store SHALL drive `mem_we`=1 and `mem_wdata`=`req_wdata` in the same cycle; `stall`=0.
REQ-004 In IDLE, a load SHALL drive `mem_re`=1 and register the selected lane into `rsp_rdata`; `rsp_valid`=1 for exactly the following cycle; `stall`=0.
- Lane select: byte lane = `addr[1:0]`, half lane = `addr[1]`.
- Sign-extend unless `req_unsigned`.
REQ-005 In IDLE, a byte or half store SHALL perform the read phase of a read-modify-write.
- Drive `mem_re`=1 and `stall`=1.
- Latch address, size and merged word (old `mem_rdata` with new lane(s) from `req_wdata[7:0]` or `[15:0]`).
- Go to MERGE.
REQ-006 In MERGE, the block SHALL drive `mem_we`=1 with the latched address and word, `stall`=0, ignore `req_*`, and return to IDLE.
REQ-007 A sub-word store SHALL therefore take exactly 2 cycles, and the next request SHALL be accepted in the cycle after MERGE.
REQ-008 `mem_we` and `mem_re` SHALL never both be 1 in the same cycle.
REQ-009 With `req_valid`=0 in IDLE, all memory strobes and `stall` SHALL be 0.
REQ-010 A misaligned access SHALL be one of the following:
- half with `addr[0]`=1
- word with `addr[1:0]`≠0
REQ-011 A misaligned access SHALL be handled as follows:
- No memory strobe.
- `misalign`=1 for one cycle following.
- `rsp_valid`=0.
- Remain in IDLE.
REQ-012 `rsp_rdata` SHALL hold its value when `rsp_valid`=0.

Reset
REQ-013 `rst` SHALL force state=IDLE, `rsp_valid`=0, `rsp_rdata`=0, `misalign`=0, and the latched address/word to 0.
REQ-014 `rst` asserted while in MERGE SHALL abort the store: `mem_we`=0 that cycle, and memory is unchanged.
REQ-015 All memory strobes and `stall` SHALL be 0 during any cycle in which `rst`=1.

Configuration
REQ-016 Macro `LSU_MISALIGN_TRAP_EN` SHALL control misalignment handling.
- Defined: REQ-010/011 apply.
- Undefined: low address bits are ignored for the access (half uses `addr[1]`, word uses the whole word), the access proceeds normally, and `misalign` is tied to 0.

Structure
REQ-017 Shared package `lsu_pkg` SHALL hold:
- size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`
- FSM state enum
- `DATA_W`=32
REQ-018 One combinational sub-module `lsu_align` SHALL implement load lane extract/extension and store lane merge; the FSM and registers live in `lsu_mem_ctrl`.

Verification
REQ-019 The bench SHALL cover these directed scenarios.
- Store word 0xDEADBEEF at 0x10, then load word 0x10: one-cycle `mem_we`, no stall; `rsp_valid` next cycle, `rsp_rdata`=0xDEADBEEF.
- Mem[0x10]=0x11223344, store byte 0xAA at 0x12: stall 1 cycle (`mem_re`), then `mem_we`, mem[0x10]=0x11AA3344.
- Mem[0x20]=0x80F0007F: load byte signed at 0x20 → 0x0000007F; at 0x23 → 0xFFFFFF80; half unsigned at 0x22 → 0x000080F0.
- Macro defined, load word at 0x21: no strobes, `misalign`=1 one cycle, `rsp_valid`=0; macro undefined: `rsp_rdata`=mem[0x20].
- Store half 0x5555 at 0x30, `rst` asserted in MERGE: `mem_we` never 1, mem[0x30] unchanged, outputs at reset values.
- Back-to-back store byte then load byte at same address: load returns the new byte; strobes never overlap.
